// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and default sizes for the fetch controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int c_XLEN               = 64;
    localparam int c_INSTRUCTION_LENGTH = c_XLEN / 2;
    localparam int c_RESET_PC           = 0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DBG   = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_reg
//  Description : Word-addressed program counter with hold / load / increment.
//                Increment wraps naturally modulo 2^XLEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int              XLEN     = c_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_pc,
    input  logic            i_inc,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;

    // Load has priority over increment; neither means hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= r_pc + XLEN'(1);
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_controller
//  Description : Fetch-stage sequencer. Owns the PC, applies stall/redirect,
//                and hands the instruction-memory write port to the debug
//                loader through a req/gnt handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int              XLEN               = c_XLEN,
    parameter int              INSTRUCTION_LENGTH = XLEN / 2,
    parameter logic [XLEN-1:0] RESET_PC           = XLEN'(c_RESET_PC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall_i,
    input  logic                          redirect_valid_i,
    input  logic [XLEN-1:0]               redirect_pc_i,
    input  logic                          dbg_req_i,
    input  logic [XLEN-1:0]               dbg_addr_i,
    input  logic [INSTRUCTION_LENGTH-1:0] dbg_instr_i,
    output logic                          dbg_gnt_o,
    output logic [XLEN-1:0]               imem_addr_o,
    output logic                          imem_wr_en_o,
    output logic [XLEN-1:0]               imem_wr_addr_o,
    output logic [INSTRUCTION_LENGTH-1:0] imem_wr_data_o,
    output logic [XLEN-1:0]               pc_o,
    output logic                          fetch_valid_o,
    output logic [XLEN-1:0]               fetch_count_o
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic              r_pend_valid;
    logic [XLEN-1:0]   r_pend_pc;
    logic [XLEN-1:0]   r_fetch_count;

    logic [XLEN-1:0]   w_pc;
    logic              w_pc_load;
    logic [XLEN-1:0]   w_pc_load_val;
    logic              w_pc_inc;
    logic              w_pend_set;
    logic              w_pend_clr;
    logic              w_count_inc;
    logic              w_fetch_valid;
    logic              w_gnt;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_pc_load),
        .i_load_pc (w_pc_load_val),
        .i_inc     (w_pc_inc),
        .o_pc      (w_pc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, PC control and handshake outputs.
    always_comb begin
        w_state_next  = r_state;
        w_pc_load     = 1'b0;
        w_pc_load_val = redirect_pc_i;
        w_pc_inc      = 1'b0;
        w_pend_set    = 1'b0;
        w_pend_clr    = 1'b0;
        w_count_inc   = 1'b0;
        w_fetch_valid = 1'b0;
        w_gnt         = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_next = dbg_req_i ? DBG : RUN;
            end
            RUN: begin
                w_fetch_valid = 1'b1;
                if (dbg_req_i) begin
                    w_state_next = DBG;
                end else if (redirect_valid_i) begin
                    w_pc_load    = 1'b1;
                    w_state_next = FLUSH;
                end else if (!stall_i) begin
                    w_pc_inc    = 1'b1;
                    w_count_inc = 1'b1;
                end
            end
            FLUSH: begin
                if (dbg_req_i) begin
                    w_state_next = DBG;
                end else if (redirect_valid_i) begin
                    w_pc_load = 1'b1;
                end else begin
                    w_state_next = RUN;
                end
            end
            DBG: begin
                // Grant follows the request so it drops in the release cycle.
                w_gnt      = dbg_req_i;
                w_pend_set = redirect_valid_i;
                if (!dbg_req_i) begin
                    w_state_next = FLUSH;
                    w_pend_clr   = 1'b1;
                    // A redirect in the release cycle is the most recent one.
                    if (redirect_valid_i) begin
                        w_pc_load = 1'b1;
                    end else if (r_pend_valid) begin
                        w_pc_load     = 1'b1;
                        w_pc_load_val = r_pend_pc;
                    end
                end
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    // Redirects captured while the debug loader owns the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
        end else if (w_pend_clr) begin
            r_pend_valid <= 1'b0;
        end else if (w_pend_set) begin
            r_pend_valid <= 1'b1;
            r_pend_pc    <= redirect_pc_i;
        end
    end

    // Count of valid fetches that advanced the PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_count_inc) begin
            r_fetch_count <= r_fetch_count + XLEN'(1);
        end
    end

    assign dbg_gnt_o      = w_gnt;
    assign imem_wr_en_o   = dbg_req_i & w_gnt;
    assign imem_wr_addr_o = w_gnt ? dbg_addr_i  : '0;
    assign imem_wr_data_o = w_gnt ? dbg_instr_i : '0;
    assign imem_addr_o    = w_pc;
    assign pc_o           = w_pc;
    assign fetch_valid_o  = w_fetch_valid;
    assign fetch_count_o  = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_controller
//  Description : Self-checking bench: directed vector table plus randomized
//                traffic against a behavioural model of the fetch sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

    localparam int XL = 64;
    localparam int IL = 32;
    localparam logic [XL-1:0] ONES = {XL{1'b1}};

    logic          clk;
    logic          rst;
    logic          stall_i;
    logic          redirect_valid_i;
    logic [XL-1:0] redirect_pc_i;
    logic          dbg_req_i;
    logic [XL-1:0] dbg_addr_i;
    logic [IL-1:0] dbg_instr_i;
    logic          dbg_gnt_o;
    logic [XL-1:0] imem_addr_o;
    logic          imem_wr_en_o;
    logic [XL-1:0] imem_wr_addr_o;
    logic [IL-1:0] imem_wr_data_o;
    logic [XL-1:0] pc_o;
    logic          fetch_valid_o;
    logic [XL-1:0] fetch_count_o;

    int checks = 0;
    int errors = 0;

    fetch_controller #(
        .XLEN               (XL),
        .INSTRUCTION_LENGTH (IL),
        .RESET_PC           ('0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .dbg_req_i        (dbg_req_i),
        .dbg_addr_i       (dbg_addr_i),
        .dbg_instr_i      (dbg_instr_i),
        .dbg_gnt_o        (dbg_gnt_o),
        .imem_addr_o      (imem_addr_o),
        .imem_wr_en_o     (imem_wr_en_o),
        .imem_wr_addr_o   (imem_wr_addr_o),
        .imem_wr_data_o   (imem_wr_data_o),
        .pc_o             (pc_o),
        .fetch_valid_o    (fetch_valid_o),
        .fetch_count_o    (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          rst;
        logic          stall;
        logic          rv;
        logic [XL-1:0] rpc;
        logic          dreq;
        logic [XL-1:0] daddr;
        logic [IL-1:0] ddata;
        logic [XL-1:0] e_pc;
        logic          e_valid;
        logic          e_gnt;
        logic [XL-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic st, input logic rv, input logic [XL-1:0] rpc,
                       input logic dq, input logic [XL-1:0] da, input logic [IL-1:0] dd,
                       input logic [XL-1:0] epc, input logic ev, input logic eg, input logic [XL-1:0] ec);
        vec_t v;
        v.rst = r; v.stall = st; v.rv = rv; v.rpc = rpc;
        v.dreq = dq; v.daddr = da; v.ddata = dd;
        v.e_pc = epc; v.e_valid = ev; v.e_gnt = eg; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic st, input logic rv, input logic [XL-1:0] rpc,
                         input logic dq, input logic [XL-1:0] da, input logic [IL-1:0] dd);
        rst = r; stall_i = st; redirect_valid_i = rv; redirect_pc_i = rpc;
        dbg_req_i = dq; dbg_addr_i = da; dbg_instr_i = dd;
    endtask

    // Write port carries the loader's address/data only while granted.
    task automatic check(input string name, input logic [XL-1:0] epc, input logic ev,
                         input logic eg, input logic [XL-1:0] ec);
        logic [XL-1:0] ewa;
        logic [IL-1:0] ewd;
        ewa = eg ? dbg_addr_i  : '0;
        ewd = eg ? dbg_instr_i : '0;
        checks++;
        if (pc_o !== epc || imem_addr_o !== epc || fetch_valid_o !== ev || dbg_gnt_o !== eg ||
            imem_wr_en_o !== eg || imem_wr_addr_o !== ewa || imem_wr_data_o !== ewd ||
            fetch_count_o !== ec) begin
            errors++;
            $display("FAIL %s: got pc=%h addr=%h v=%b gnt=%b we=%b wa=%h wd=%h cnt=%0d ; want pc=%h v=%b gnt=%b we=%b wa=%h wd=%h cnt=%0d",
                     name, pc_o, imem_addr_o, fetch_valid_o, dbg_gnt_o, imem_wr_en_o,
                     imem_wr_addr_o, imem_wr_data_o, fetch_count_o,
                     epc, ev, eg, eg, ewa, ewd, ec);
        end
    endtask

    // Behavioural model: the machine is booting, owned by the loader,
    // paying a refetch bubble, or fetching.
    logic          m_boot, m_dbg, m_bubble, m_pend_v;
    logic [XL-1:0] m_pc, m_pend, m_cnt;

    task automatic model_step();
        if (rst) begin
            m_boot = 1'b1; m_dbg = 1'b0; m_bubble = 1'b0; m_pend_v = 1'b0;
            m_pc = '0; m_cnt = '0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_dbg  = dbg_req_i;
        end else if (m_dbg) begin
            if (redirect_valid_i) begin
                m_pend_v = 1'b1;
                m_pend   = redirect_pc_i;
            end
            if (!dbg_req_i) begin
                m_dbg    = 1'b0;
                m_bubble = 1'b1;
                if (m_pend_v) m_pc = m_pend;
                m_pend_v = 1'b0;
            end
        end else if (m_bubble) begin
            if (dbg_req_i) begin
                m_dbg = 1'b1; m_bubble = 1'b0;
            end else if (redirect_valid_i) begin
                m_pc = redirect_pc_i;
            end else begin
                m_bubble = 1'b0;
            end
        end else begin
            if (dbg_req_i) begin
                m_dbg = 1'b1;
            end else if (redirect_valid_i) begin
                m_pc = redirect_pc_i; m_bubble = 1'b1;
            end else if (!stall_i) begin
                m_pc  = m_pc + 1;
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    initial begin
        int burst;
        logic          r_r, r_st, r_rv, r_dq;
        logic [XL-1:0] r_rpc, r_da;
        logic [IL-1:0] r_dd;

        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);

        //  rst st rv rpc          dq addr data          e_pc        v  g  cnt
        add(1, 0, 0, 0,            0, 0, 0,             0,          0, 0, 0);  // reset state
        add(0, 0, 0, 0,            0, 0, 0,             0,          0, 0, 0);  // BOOT
        add(0, 0, 0, 0,            0, 0, 0,             0,          1, 0, 0);
        add(0, 0, 0, 0,            0, 0, 0,             1,          1, 0, 1);
        add(0, 0, 0, 0,            0, 0, 0,             2,          1, 0, 2);
        add(0, 0, 0, 0,            0, 0, 0,             3,          1, 0, 3);
        add(0, 0, 0, 0,            0, 0, 0,             4,          1, 0, 4);
        add(0, 1, 0, 0,            0, 0, 0,             5,          1, 0, 5);  // stall
        add(0, 1, 0, 0,            0, 0, 0,             5,          1, 0, 5);
        add(0, 0, 0, 0,            0, 0, 0,             5,          1, 0, 5);
        add(0, 0, 0, 0,            0, 0, 0,             6,          1, 0, 6);
        add(0, 1, 1, 64'h40,       0, 0, 0,             7,          1, 0, 7);  // redirect beats stall
        add(0, 0, 0, 0,            0, 0, 0,             64'h40,     0, 0, 7);  // bubble
        add(0, 0, 0, 0,            0, 0, 0,             64'h40,     1, 0, 7);
        add(0, 0, 0, 0,            1, 64'h9, 32'hdead,  64'h41,     1, 0, 8);  // req, no write yet
        add(0, 0, 0, 0,            1, 0, 32'h00000013,  64'h41,     0, 1, 8);
        add(0, 0, 0, 0,            1, 1, 32'h00500093,  64'h41,     0, 1, 8);
        add(0, 0, 0, 0,            1, 2, 32'h00A00113,  64'h41,     0, 1, 8);
        add(0, 0, 0, 0,            0, 3, 32'h1234,      64'h41,     0, 0, 8);  // release
        add(0, 0, 0, 0,            0, 0, 0,             64'h41,     0, 0, 8);  // bubble
        add(0, 0, 0, 0,            0, 0, 0,             64'h41,     1, 0, 8);
        add(0, 0, 0, 0,            1, 0, 0,             64'h42,     1, 0, 9);
        add(0, 0, 1, 64'h80,       1, 5, 32'haa,        64'h42,     0, 1, 9);  // redirect held
        add(0, 0, 1, 64'h90,       1, 6, 32'hbb,        64'h42,     0, 1, 9);  // last wins
        add(0, 1, 0, 0,            1, 7, 32'hcc,        64'h42,     0, 1, 9);
        add(0, 0, 0, 0,            0, 0, 0,             64'h42,     0, 0, 9);
        add(0, 0, 0, 0,            0, 0, 0,             64'h90,     0, 0, 9);
        add(0, 0, 0, 0,            0, 0, 0,             64'h90,     1, 0, 9);
        add(0, 0, 1, ONES,         0, 0, 0,             64'h91,     1, 0, 10); // redirect to max
        add(0, 0, 0, 0,            0, 0, 0,             ONES,       0, 0, 10);
        add(0, 0, 0, 0,            0, 0, 0,             ONES,       1, 0, 10);
        add(0, 0, 0, 0,            0, 0, 0,             0,          1, 0, 11); // wrapped
        add(0, 0, 0, 0,            1, 0, 0,             1,          1, 0, 12);
        add(0, 0, 1, 64'h55,       1, 8, 32'h77,        1,          0, 1, 12);
        add(1, 0, 0, 0,            1, 9, 32'h88,        1,          0, 1, 12); // reset mid-burst
        add(0, 0, 0, 0,            0, 0, 0,             0,          0, 0, 0);  // gnt gone
        add(0, 0, 0, 0,            0, 0, 0,             0,          1, 0, 0);  // no pending pc
        add(0, 0, 0, 0,            0, 0, 0,             1,          1, 0, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].rpc,
                  vecs[i].dreq, vecs[i].daddr, vecs[i].ddata);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_gnt, vecs[i].e_cnt);
            @(posedge clk);
            @(negedge clk);
        end

        // Randomized traffic, starting from a clean reset.
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        @(posedge clk);
        model_step();
        @(negedge clk);
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            r_r  = ($urandom_range(0, 99) == 0);
            r_st = ($urandom_range(0, 3) == 0);
            r_rv = ($urandom_range(0, 7) == 0);
            r_rpc = ($urandom_range(0, 9) == 0) ? ONES - XL'($urandom_range(0, 2))
                                                : {$urandom(), $urandom()};
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(1, 6);
            r_dq = (burst > 0);
            if (burst > 0) burst--;
            r_da = {$urandom(), $urandom()};
            r_dd = $urandom();
            drive(r_r, r_st, r_rv, r_rpc, r_dq, r_da, r_dd);
            #1;
            check($sformatf("rand%0d", n), m_pc, !(m_boot || m_dbg || m_bubble),
                  m_dbg && dbg_req_i, m_cnt);
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
